alu_seq_ctrl: RTL and testbench

- Parametrised successor to the fixed ALU control sequencer in the microcontroller datapath.
- Drives the shared-bus control strobes for one register-to-register ALU instruction:
  - source 1 read
  - optional source 2 read
  - ALU latch
  - write-back to the destination register
- Register count, field widths and inter-phase settle time are generic.
- Adds a start/done/abort handshake, unary-op support and illegal-instruction error reporting.

---
 rtl/alu_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Bus-strobe sequencer for one register-to-register ALU instruction, with a
// start/done/abort handshake, unary-op support and illegal-instruction reporting.
module alu_seq_ctrl #(
    parameter int unsigned OPW        = 4,
    parameter int unsigned SELW       = 6,
    parameter int unsigned NUM_REGS   = 6,
    parameter int unsigned ALU_OP_MIN = 9,
    parameter int unsigned WAIT_CYC   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [OPW+2*SELW-1:0] instr,
    output logic [NUM_REGS-1:0]   reg_out_en,
    output logic [NUM_REGS-1:0]   reg_in_en,
    output logic                  pc_inc,
    output logic                  alu_in1,
    output logic                  alu_in2,
    output logic                  alu_out_latch,
    output logic                  alu_out_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned CNTW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = (WAIT_CYC > 0) ? CNTW'(WAIT_CYC - 1) : '0;

    typedef enum logic [3:0] {
        StIdle, StS1Drv, StS1Lat, StGap, StS2Drv, StS2Lat,
        StExec, StWbDrv, StWbLat, StDone, StErr
    } state_e;

    state_e          state_q, state_d;
    logic [SELW-1:0] f1_q, f1_d, f2_q, f2_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [OPW-1:0]  in_op;
    logic [SELW-1:0] in_f1, in_f2;
    logic            in_illegal;

    logic [NUM_REGS-1:0] rout_d, rin_d;
    logic pc_d, in1_d, in2_d, olat_d, oen_d, busy_d, done_d, err_d;

    // The opcode only matters for the legality check at capture, so it is not held.
    assign {in_op, in_f1, in_f2} = instr;
    assign in_illegal = (32'(in_op) < ALU_OP_MIN) || (32'(in_f1) >= NUM_REGS) ||
                        ((32'(in_f2) >= NUM_REGS) && (in_f2 != '1));

    function automatic logic [NUM_REGS-1:0] sel_dec(input logic [SELW-1:0] sel);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) v[i] = (32'(sel) == i);
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        cnt_d   = cnt_q;
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        f1_d    = in_f1;
                        f2_d    = in_f2;
                        state_d = in_illegal ? StErr : StS1Drv;
                    end
                end
                StS1Drv: state_d = StS1Lat;
                StS1Lat: begin
                    // All-ones f2 marks a unary op: skip the second operand entirely.
                    if (f2_q == '1) begin
                        state_d = StExec;
                    end else if (WAIT_CYC == 0) begin
                        state_d = StS2Drv;
                    end else begin
                        state_d = StGap;
                        cnt_d   = '0;
                    end
                end
                StGap: begin
                    if (cnt_q == CNT_LAST) state_d = StS2Drv;
                    else cnt_d = cnt_q + 1'b1;
                end
                StS2Drv: state_d = StS2Lat;
                StS2Lat: state_d = StExec;
                StExec:  state_d = StWbDrv;
                StWbDrv: state_d = StWbLat;
                StWbLat: state_d = StDone;
                StDone:  state_d = StIdle;
                StErr:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are decoded from the next state so they leave the flops with the state.
    always_comb begin
        rout_d = '0;
        rin_d  = '0;
        pc_d   = 1'b0;
        in1_d  = 1'b0;
        in2_d  = 1'b0;
        olat_d = 1'b0;
        oen_d  = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        busy_d = (state_d != StIdle);
        case (state_d)
            StS1Drv: begin
                pc_d   = 1'b1;
                rout_d = sel_dec(f1_d);
            end
            StS1Lat: begin
                rout_d = sel_dec(f1_d);
                in1_d  = 1'b1;
            end
            StS2Drv: rout_d = sel_dec(f2_d);
            StS2Lat: begin
                rout_d = sel_dec(f2_d);
                in2_d  = 1'b1;
            end
            StExec:  olat_d = 1'b1;
            StWbDrv: oen_d = 1'b1;
            StWbLat: begin
                oen_d = 1'b1;
                rin_d = sel_dec(f1_d);
            end
            StDone:  done_d = 1'b1;
            StErr: begin
                done_d = 1'b1;
                err_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            f1_q          <= '0;
            f2_q          <= '0;
            cnt_q         <= '0;
            reg_out_en    <= '0;
            reg_in_en     <= '0;
            pc_inc        <= 1'b0;
            alu_in1       <= 1'b0;
            alu_in2       <= 1'b0;
            alu_out_latch <= 1'b0;
            alu_out_en    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_q       <= state_d;
            f1_q          <= f1_d;
            f2_q          <= f2_d;
            cnt_q         <= cnt_d;
            reg_out_en    <= rout_d;
            reg_in_en     <= rin_d;
            pc_inc        <= pc_d;
            alu_in1       <= in1_d;
            alu_in2       <= in2_d;
            alu_out_latch <= olat_d;
            alu_out_en    <= oen_d;
            busy          <= busy_d;
            done          <= done_d;
            err           <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: default, zero-wait and three-wait instances
// share one stimulus; per-cycle traces are checked against hand-computed values.
module tb_alu_seq_ctrl;

    localparam int MAXC = 32;
    localparam int NV   = 8;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] instr;

    logic [5:0] d_rout, d_rin, z_rout, z_rin, t_rout, t_rin;
    logic d_pc, d_in1, d_in2, d_olat, d_oen, d_busy, d_done, d_err;
    logic z_pc, z_in1, z_in2, z_olat, z_oen, z_busy, z_done, z_err;
    logic t_pc, t_in1, t_in2, t_olat, t_oen, t_busy, t_done, t_err;

    int total = 0;
    int bad   = 0;
    int inv_viol = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_seq_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .instr(instr),
        .reg_out_en(d_rout), .reg_in_en(d_rin), .pc_inc(d_pc), .alu_in1(d_in1),
        .alu_in2(d_in2), .alu_out_latch(d_olat), .alu_out_en(d_oen), .busy(d_busy),
        .done(d_done), .err(d_err)
    );

    alu_seq_ctrl #(.WAIT_CYC(0)) u_w0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .instr(instr),
        .reg_out_en(z_rout), .reg_in_en(z_rin), .pc_inc(z_pc), .alu_in1(z_in1),
        .alu_in2(z_in2), .alu_out_latch(z_olat), .alu_out_en(z_oen), .busy(z_busy),
        .done(z_done), .err(z_err)
    );

    alu_seq_ctrl #(.WAIT_CYC(3)) u_w3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .instr(instr),
        .reg_out_en(t_rout), .reg_in_en(t_rin), .pc_inc(t_pc), .alu_in1(t_in1),
        .alu_in2(t_in2), .alu_out_latch(t_olat), .alu_out_en(t_oen), .busy(t_busy),
        .done(t_done), .err(t_err)
    );

    // Bus-conflict and one-hot invariants on every instance.
    logic viol;
    assign viol = !$onehot0(d_rout) || !$onehot0(d_rin) || ((|d_rout) && d_oen) ||
                  !$onehot0(z_rout) || !$onehot0(z_rin) || ((|z_rout) && z_oen) ||
                  !$onehot0(t_rout) || !$onehot0(t_rin) || ((|t_rout) && t_oen);
    always @(negedge clk) if (rst && viol) inv_viol <= inv_viol + 1;

    typedef struct packed {
        logic [5:0] rout;
        logic [5:0] rin;
        logic pc, in1, in2, olat, oen, busy, done, err, done0, done3;
    } samp_t;
    samp_t tr [MAXC];

    typedef struct {
        logic [15:0] ins;
        int          done_c;
        logic        err;
        int          n_in2;
        logic [5:0]  rin;
        int          rin_c;
        logic [5:0]  rout1;
        int          nstb;
        int          done0_c;
        int          done3_c;
    } vec_t;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Bit c of smask/amask is driven during cycle c; cycle 0 is the start-sampling cycle.
    task automatic run(input logic [15:0] ins, input logic [31:0] smask,
                       input logic [31:0] amask, input int n);
        for (int c = 0; c < MAXC; c++) tr[c] = '0;
        @(negedge clk);
        instr = ins;
        start = smask[0];
        abort = amask[0];
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            tr[c] = '{rout: d_rout, rin: d_rin, pc: d_pc, in1: d_in1, in2: d_in2,
                      olat: d_olat, oen: d_oen, busy: d_busy, done: d_done, err: d_err,
                      done0: z_done, done3: t_done};
            start = smask[c];
            abort = amask[c];
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
    endtask

    function automatic int count_done(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (tr[c].done) n++;
        return n;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, d0, d3, n2, rc, ns, acc;
        logic [5:0] rinor;

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        instr = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'({d_rout, d_rin, d_pc, d_in1, d_in2, d_olat, d_oen,
                                 d_busy, d_done, d_err}), 0);
        rst = 1'b1;

        vecs[0] = '{{4'hA, 6'd2, 6'd3},   9, 1'b0, 1, 6'b000100, 8, 6'b000100, 7, 8, 11};
        vecs[1] = '{{4'hF, 6'd5, 6'h3F},  6, 1'b0, 0, 6'b100000, 5, 6'b100000, 5, 6, 6};
        vecs[2] = '{{4'h3, 6'd0, 6'd1},   1, 1'b1, 0, 6'b000000, 0, 6'b000000, 0, 1, 1};
        vecs[3] = '{{4'h9, 6'd6, 6'd0},   1, 1'b1, 0, 6'b000000, 0, 6'b000000, 0, 1, 1};
        vecs[4] = '{{4'h9, 6'd0, 6'd5},   9, 1'b0, 1, 6'b000001, 8, 6'b000001, 7, 8, 11};
        vecs[5] = '{{4'h9, 6'd1, 6'd6},   1, 1'b1, 0, 6'b000000, 0, 6'b000000, 0, 1, 1};
        vecs[6] = '{{4'hC, 6'd4, 6'h3F},  6, 1'b0, 0, 6'b010000, 5, 6'b010000, 5, 6, 6};
        vecs[7] = '{{4'h8, 6'd2, 6'd3},   1, 1'b1, 0, 6'b000000, 0, 6'b000000, 0, 1, 1};

        for (int v = 0; v < NV; v++) begin
            run(vecs[v].ins, 32'h1, 32'h0, 14);
            dc = 0; d0 = 0; d3 = 0; n2 = 0; rc = 0; ns = 0; rinor = '0;
            for (int c = 1; c <= 14; c++) begin
                if (tr[c].done  && dc == 0) dc = c;
                if (tr[c].done0 && d0 == 0) d0 = c;
                if (tr[c].done3 && d3 == 0) d3 = c;
                if (tr[c].in2) n2++;
                if (tr[c].rin != 0) begin
                    rinor = rinor | tr[c].rin;
                    rc = c;
                end
                if (|{tr[c].rout, tr[c].rin, tr[c].pc, tr[c].in1, tr[c].in2,
                      tr[c].olat, tr[c].oen}) ns++;
            end
            check($sformatf("v%0d_done_cyc", v), dc, vecs[v].done_c);
            check($sformatf("v%0d_err", v), 32'(tr[dc].err), 32'(vecs[v].err));
            check($sformatf("v%0d_in2_cnt", v), n2, vecs[v].n_in2);
            check($sformatf("v%0d_rin", v), 32'(rinor), 32'(vecs[v].rin));
            check($sformatf("v%0d_rin_cyc", v), rc, vecs[v].rin_c);
            check($sformatf("v%0d_rout_c1", v), 32'(tr[1].rout), 32'(vecs[v].rout1));
            check($sformatf("v%0d_strobe_cycles", v), ns, vecs[v].nstb);
            check($sformatf("v%0d_busy_after", v), 32'(tr[dc + 1].busy), 0);
            check($sformatf("v%0d_w0_done_cyc", v), d0, vecs[v].done0_c);
            check($sformatf("v%0d_w3_done_cyc", v), d3, vecs[v].done3_c);
        end

        // Full cycle-by-cycle trace of a binary op.
        run({4'hA, 6'd2, 6'd3}, 32'h1, 32'h0, 12);
        check("bin_rout_c1", 32'(tr[1].rout), 32'h04);
        check("bin_pc_c1", 32'(tr[1].pc), 1);
        check("bin_rout_c2", 32'(tr[2].rout), 32'h04);
        check("bin_in1_c2", 32'(tr[2].in1), 1);
        check("bin_gap_c3", 32'({tr[3].rout, tr[3].pc, tr[3].in1, tr[3].in2, tr[3].olat,
                                 tr[3].oen, tr[3].busy}), 1);
        check("bin_rout_c4", 32'(tr[4].rout), 32'h08);
        check("bin_rout_c5", 32'(tr[5].rout), 32'h08);
        check("bin_in2_c5", 32'(tr[5].in2), 1);
        check("bin_olat_c6", 32'(tr[6].olat), 1);
        check("bin_oen_c7", 32'({tr[7].oen, tr[7].rin}), 32'h40);
        check("bin_wb_c8", 32'({tr[8].oen, tr[8].rin}), 32'h44);
        check("bin_done_c9", 32'({tr[9].done, tr[9].err, tr[9].busy}), 32'h5);
        check("bin_idle_c10", 32'(tr[10].busy), 0);

        // Abort during WB_DRV.
        run({4'hA, 6'd2, 6'd3}, 32'h1, 32'h1 << 7, 12);
        check("abort_oen_c7", 32'(tr[7].oen), 1);
        check("abort_idle_c8", 32'(tr[8].busy), 0);
        acc = 0;
        for (int c = 1; c <= 12; c++) if (tr[c].rin != 0 || tr[c].err) acc++;
        check("abort_no_rin_err", acc, 0);
        check("abort_no_done", count_done(1, 12), 0);

        // Start and abort together in IDLE.
        run({4'hA, 6'd2, 6'd3}, 32'h1, 32'h1, 4);
        acc = 0;
        for (int c = 1; c <= 4; c++) if (tr[c].busy) acc++;
        check("start_abort_idle", acc, 0);

        // Starts during the op are ignored; a start right after DONE is accepted.
        run({4'hA, 6'd2, 6'd3}, 32'h1 | (32'h1 << 3) | (32'h1 << 9) | (32'h1 << 10), 32'h0, 20);
        check("busy_start_one_done", count_done(1, 10), 1);
        check("busy_start_done_c9", 32'(tr[9].done), 1);
        check("busy_start_idle_c10", 32'(tr[10].busy), 0);
        check("restart_c11", 32'({tr[11].busy, tr[11].pc}), 32'h3);
        check("restart_done_c19", 32'(tr[19].done), 1);

        // Asynchronous reset in S2_LAT.
        @(negedge clk);
        instr = {4'hA, 6'd2, 6'd3};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid_in2_pre", 32'(d_in2), 1);
        rst = 1'b0;
        #1;
        check("rstmid_outs", 32'({d_rout, d_rin, d_pc, d_in1, d_in2, d_olat, d_oen,
                                  d_busy, d_done, d_err}), 0);
        check("rstmid_w3_outs", 32'({t_rout, t_rin, t_pc, t_in1, t_in2, t_olat, t_oen,
                                     t_busy, t_done, t_err}), 0);
        @(negedge clk);
        rst = 1'b1;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (d_busy || d_done) acc++;
        end
        check("rstmid_stays_idle", acc, 0);

        check("invariants", inv_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
